uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit controller and serializer for the UART TX path. It sits directly downstream of the parity calculator and consumes its registered par_bit. It accepts a parallel word on Data_Valid and drives the serial line with a start bit, LSB-first data, an optional parity bit and a stop bit. Each bit lasts one clock; baud pacing comes from the clock enable or clock supplied upstream.

Parameters:
DATA_WIDTH, 8, width of P_DATA and number of serialized data bits (must be >= 2)

Ports:
uart_tx_ctrl_CLK  input  1  block clock; all state changes on rising edge
uart_tx_ctrl_RST  input  1  reset; synchronous, active-high
P_DATA  input  DATA_WIDTH  parallel word to transmit
Data_Valid  input  1  single-cycle request; P_DATA and PAR_EN valid in same cycle
PAR_EN  input  1  1 = insert parity bit in the frame
par_bit  input  1  parity bit from the parity calculator; registered there on the same Data_Valid edge
TX_OUT  output  1  serial line, idle high
Busy  output  1  high while a frame is in progress

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high. While uart_tx_ctrl_RST=1 at a rising edge, the block loads: state=IDLE, TX_OUT=1, Busy=0, bit counter=0, data shift register=0, latched parity=0, latched PAR_EN=0.
- Reset asserted mid-frame aborts the frame at the next edge. TX_OUT returns to 1 immediately; there is no stop-bit completion.
- Outputs: all outputs are registered. TX_OUT and Busy are decoded from next-state logic, so each tracks its state with no extra cycle of lag.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If Data_Valid=1 at an edge:
  - latch P_DATA into the shift register;
  - latch PAR_EN;
  - clear the counter;
  - go to START.
- START: lasts 1 cycle. TX_OUT=0, Busy=1.
  - par_bit is valid in this cycle (one cycle after acceptance). Latch it here.
  - Go to DATA.
- DATA: lasts DATA_WIDTH cycles. TX_OUT = shift register bit 0. Shift right by one each cycle and increment the counter.
  - When counter = DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, otherwise go to STOP.
- PARITY: lasts 1 cycle. TX_OUT = latched parity. Go to STOP.
- STOP: lasts 1 cycle. TX_OUT=1, Busy=1. Go to IDLE.
- Latency: TX_OUT falls in the first cycle after the accepting edge.
- Frame length: DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without.
- Busy=0 for at least one IDLE cycle between frames. No back-to-back chaining from STOP.
- Data_Valid while Busy=1 is ignored. P_DATA and PAR_EN changes mid-frame do not affect the current frame.
  - The parity calculator may recompute par_bit on such a pulse. The frame is unaffected because parity was latched in START.
- Counter width is $clog2(DATA_WIDTH). No wrap beyond DATA_WIDTH-1 is reachable.
- Data_Valid on the same edge as reset: reset wins and the word is dropped.
- PAR_TYP is not an input. Parity polarity is owned entirely by the parity calculator.

Test Plan:
- Reset: hold uart_tx_ctrl_RST=1 for 3 cycles with Data_Valid=1 and P_DATA=8'hFF -> TX_OUT=1 and Busy=0 throughout and 1 cycle after release. No frame starts.
- Even frame: P_DATA=8'hA5, PAR_EN=1, with the parity calculator driven PAR_TYP=0 (par_bit=0) -> TX_OUT sequence is 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles. Busy is high for exactly those 11 cycles, then low.
- No parity: P_DATA=8'h3C, PAR_EN=0 -> TX_OUT sequence is 0,0,0,1,1,1,1,0,0,1 over 10 cycles. No parity slot; Busy high for 10 cycles.
- Odd parity: P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 (par_bit=0) -> the parity slot (cycle 10) is 0.
  - Repeat with PAR_TYP=0 -> the parity slot is 1.
- Ignore while busy: start 8'hA5 with PAR_EN=1. Pulse Data_Valid with P_DATA=8'h00 during the 4th data bit -> the frame completes exactly as in the even-frame case, including parity 0. No second frame follows.
- Mid-frame reset: assert reset during the 2nd data bit -> TX_OUT=1 and Busy=0 on the next edge.
  - A new Data_Valid with 8'h80 one cycle after reset release -> a clean 11-cycle frame 0,0,0,0,0,0,0,0,1,p,1, where p = the par_bit delivered in START.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as start bit, LSB-first data,
// optional parity and stop bit, one bit per clock, with registered TX_OUT/Busy.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  uart_tx_ctrl_CLK,
    input  logic                  uart_tx_ctrl_RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  par_lat, par_nxt;
    logic                  pen_lat, pen_nxt;
    logic                  tx_nxt;

    // TX_OUT is computed for the state being entered, so the registered line
    // changes on the same edge as the state register.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        par_nxt   = par_lat;
        pen_nxt   = pen_lat;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    shreg_nxt = P_DATA;
                    pen_nxt   = PAR_EN;
                    cnt_nxt   = '0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                // The parity calculator registers par_bit on the accepting edge.
                par_nxt   = par_bit;
                state_nxt = DATA;
                tx_nxt    = shreg[0];
                shreg_nxt = shreg >> 1;
            end
            DATA: begin
                if (cnt == LAST_BIT) begin
                    if (pen_lat) begin
                        state_nxt = PARITY;
                        tx_nxt    = par_lat;
                    end else begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                end
            end
            PARITY: state_nxt = STOP;
            STOP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge uart_tx_ctrl_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (uart_tx_ctrl_RST) begin
            state   <= IDLE;
            TX_OUT  <= 1'b1;
            Busy    <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            par_lat <= 1'b0;
            pen_lat <= 1'b0;
        end else begin
            state   <= state_nxt;
            TX_OUT  <= tx_nxt;
            Busy    <= (state_nxt != IDLE);
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            par_lat <= par_nxt;
            pen_lat <= pen_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame bit sequences, Busy window, reset
// behaviour, mid-frame requests, with a behavioural upstream parity calculator.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_bit;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .uart_tx_ctrl_CLK(clk),
        .uart_tx_ctrl_RST(rst),
        .P_DATA(p_data),
        .Data_Valid(data_valid),
        .PAR_EN(par_en),
        .par_bit(par_bit),
        .TX_OUT(tx_out),
        .Busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream parity calculator: even parity XOR PAR_TYP, registered on Data_Valid.
    always @(posedge clk) begin
        if (rst) par_bit <= 1'b0;
        else if (data_valid) par_bit <= (^p_data) ^ par_typ;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, tx_out, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // exp holds the frame first-bit-at-MSB; inject >= 0 pulses a new request
    // (P_DATA=0, parity type flipped) during frame cycle 'inject'.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic [10:0] exp, input int len, input int inject);
        p_data     = d;
        par_en     = pe;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_bit%0d", tag, i), tx_out, exp[len-1-i]);
            check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
            if (i == inject) begin
                data_valid = 1'b1;
                p_data     = 8'h00;
                par_en     = 1'b0;
                par_typ    = 1'b1;
            end
            tick();
            data_valid = 1'b0;
        end
        check_idle({tag, "_end"});
        tick();
        check_idle({tag, "_after"});
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b1;
        p_data     = 8'hFF;
        par_en     = 1'b1;
        par_typ    = 1'b0;

        // Reset held three cycles with a pending request.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("reset%0d", i));
        end
        rst        = 1'b0;
        data_valid = 1'b0;
        tick();
        check_idle("reset_release");

        par_typ = 1'b0;
        run_frame("even_a5", 8'hA5, 1'b1, 11'b01010010101, 11, -1);
        run_frame("nopar_3c", 8'h3C, 1'b0, 11'b00001111001, 10, -1);
        par_typ = 1'b1;
        run_frame("odd_01", 8'h01, 1'b1, 11'b01000000001, 11, -1);
        par_typ = 1'b0;
        run_frame("even_01", 8'h01, 1'b1, 11'b01000000011, 11, -1);
        // Request during the 4th data bit (frame cycle 4) must be ignored.
        par_typ = 1'b0;
        run_frame("busy_ign", 8'hA5, 1'b1, 11'b01010010101, 11, 4);
        tick();
        check_idle("busy_ign_no_second");

        // Mid-frame reset during the 2nd data bit.
        par_typ    = 1'b0;
        p_data     = 8'hA5;
        par_en     = 1'b1;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("abort_start_tx", tx_out, 1'b0);
        tick();
        check("abort_d0_tx", tx_out, 1'b1);
        tick();
        check("abort_d1_tx", tx_out, 1'b0);
        check("abort_d1_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check_idle("abort_reset");
        rst = 1'b0;
        tick();
        check_idle("abort_release");
        // 8'h80 has odd weight, so with PAR_TYP=0 the calculator delivers p=1.
        run_frame("post_rst_80", 8'h80, 1'b1, 11'b00000000111, 11, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
